// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM timer family.
package pwm_pkg;
  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  // Reset defaults; sliced down to the block's WIDTH / PRESCALE_W.
  localparam logic [31:0] PER_RST  = 32'hFFFF_FFFF;
  localparam logic [31:0] DUTY_RST = 32'h0;
  localparam logic [31:0] PSC_RST  = 32'h0;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
    return ch * w;
  endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// Reload counter: tick_o every reload_i+1 clocks; clr_i holds it at 0.
module pwm_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic [W-1:0] reload_i,
  output logic         tick_o,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = !clr_i && (cnt_q == reload_i);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM on a shared prescaler/period counter, edge or center
// aligned, with all settings double-buffered to the period boundary.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      update_req,
  input  logic                      mode,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic [CHANNELS-1:0]       polarity,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      cycle_start,
  output logic                      update_pending
);
  typedef struct packed {
    logic                             mode;
    logic [PRESCALE_W-1:0]            psc;
    logic [WIDTH-1:0]                 per;
    logic [CHANNELS-1:0][WIDTH-1:0]   duty;
    logic [CHANNELS-1:0]              pol;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    mode: MODE_EDGE,
    psc:  PSC_RST[PRESCALE_W-1:0],
    per:  PER_RST[WIDTH-1:0],
    duty: {CHANNELS{DUTY_RST[WIDTH-1:0]}},
    pol:  '0
  };

  cfg_t                           cfg_in, act_q, act_d, shd_q, shd_d;
  logic                           pend_q, pend_d;
  logic [CHANNELS-1:0][WIDTH-1:0] duty_in;
  logic [WIDTH-1:0]               cnt_q, cnt_d;
  dir_e                           dir_q, dir_d;
  logic                           bnd;
  logic                           tick;
  logic [PRESCALE_W-1:0]          psc_cnt;
  logic [CHANNELS-1:0]            raw, pwm_d, pwm_q;
  logic                           cs_d, cs_q, ctr_idle;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_din
    assign duty_in[gi] = duty[ch_lsb(gi, WIDTH) +: WIDTH];
  end

  assign cfg_in = {mode, prescale, period, duty_in, polarity};

  pwm_prescaler #(.W(PRESCALE_W)) u_psc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (!enable),
    .reload_i(act_q.psc),
    .tick_o  (tick),
    .cnt_o   (psc_cnt)
  );

  // Period counter; bnd marks the tick that closes a period.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    bnd   = 1'b0;
    if (!enable) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      if (act_q.mode == MODE_EDGE) begin
        dir_d = DIR_UP;
        if (cnt_q == act_q.per) begin
          cnt_d = '0;
          bnd   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (act_q.per == '0) begin
        cnt_d = '0;
        dir_d = DIR_UP;
        bnd   = 1'b1;
      end else if (dir_q == DIR_UP) begin
        if (cnt_q == act_q.per - 1'b1) dir_d = DIR_DOWN;
        else                            cnt_d = cnt_q + 1'b1;
      end else begin
        if (cnt_q == '0) begin
          dir_d = DIR_UP;
          bnd   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  // Boundary load wins; a request landing on the boundary bypasses the shadow.
  always_comb begin
    shd_d  = shd_q;
    act_d  = act_q;
    pend_d = pend_q;
    if (update_req) begin
      shd_d  = cfg_in;
      pend_d = 1'b1;
    end
    if (bnd && update_req) begin
      act_d  = cfg_in;
      pend_d = 1'b0;
    end else if ((bnd || !enable) && pend_q) begin
      act_d  = shd_q;
      pend_d = update_req;
    end
  end

  assign ctr_idle = (act_q.mode == MODE_CENTER) && (act_q.per == '0);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign raw[gi] = !ctr_idle && (cnt_q < act_q.duty[gi]);
  end

  assign pwm_d = enable ? (raw ^ act_q.pol) : act_q.pol;
  assign cs_d  = enable && (cnt_q == '0) && (psc_cnt == '0) && (dir_q == DIR_UP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= CFG_RST;
      shd_q  <= CFG_RST;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      pwm_q  <= '0;
      cs_q   <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      pwm_q  <= pwm_d;
      cs_q   <= cs_d;
    end
  end

  assign pwm_out        = pwm_q;
  assign cycle_start    = cs_q;
  assign update_pending = pend_q;
endmodule
